fp16_vec_mul_seq: RTL

Vector front-end for the FP16 multiplier pipeline. Accepts one pair of LANES-element FP16 operand vectors through a valid/ready handshake, issues one element pair per cycle into the multiplier's `data1`/`data2`/`input_valid` port, and collects the in-order `datanew`/`output_update` results into an output vector. It sits directly upstream and downstream of the multiplier, closing the loop around it for the vector processor's multiply instruction.

---
 rtl/fp16_vec_pkg.sv | 32 +++
 rtl/fp16_vec_collector.sv | 49 ++++
 rtl/fp16_vec_mul_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/fp16_vec_pkg.sv
// Shared types and lane helpers for the FP16 vector multiply sequencer.
// Vectors are packed with lane i at bits [16i+15:16i].
package fp16_vec_pkg;

  localparam int FP16_W        = 16;
  localparam int DEFAULT_LANES = 8;
  localparam int MAX_LANES     = 32;
  localparam int MAX_VEC_W     = FP16_W * MAX_LANES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

  // Helpers take a vector zero-extended to MAX_VEC_W so one function serves every LANES.
  function automatic logic [FP16_W-1:0] lane_get(input logic [MAX_VEC_W-1:0] vec,
                                                 input int idx);
    return vec[idx*FP16_W +: FP16_W];
  endfunction

  function automatic logic [MAX_VEC_W-1:0] lane_put(input logic [MAX_VEC_W-1:0] vec,
                                                    input int idx,
                                                    input logic [FP16_W-1:0] val);
    logic [MAX_VEC_W-1:0] r;
    r = vec;
    r[idx*FP16_W +: FP16_W] = val;
    return r;
  endfunction

endpackage

// File: rtl/fp16_vec_collector.sv
// Write-back side of the sequencer: counts in-order multiplier results into the
// output register bank and flags updates that arrive while nothing is in flight.
module fp16_vec_collector
  import fp16_vec_pkg::*;
#(
  parameter int LANES = DEFAULT_LANES,
  parameter int IDXW  = $clog2(LANES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      active,
  input  logic                      mul_update,
  input  logic [FP16_W-1:0]         mul_result,
  output logic [FP16_W*LANES-1:0]   vec_out,
  output logic                      last_wr,
  output logic                      seq_err
);

  localparam int              VEC_W    = FP16_W * LANES;
  localparam logic [IDXW:0]   LAST_IDX = (IDXW+1)'(LANES - 1);
  localparam logic [IDXW:0]   IDX_ONE  = (IDXW+1)'(1);

  logic [IDXW:0] col_idx;
  logic          wr;

  assign wr      = active && mul_update;
  assign last_wr = wr && (col_idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_idx <= '0;
      vec_out <= '0;
      seq_err <= 1'b0;
    end else begin
      if (start) begin
        col_idx <= '0;
      end else if (wr) begin
        vec_out <= VEC_W'(lane_put(MAX_VEC_W'(vec_out), int'(col_idx), mul_result));
        col_idx <= col_idx + IDX_ONE;
      end
      // Sticky until reset: a stray result means the multiplier and sequencer lost sync.
      if (mul_update && !active) begin
        seq_err <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp16_vec_mul_seq.sv
// Vector front-end for the FP16 multiplier: accepts an operand-vector pair,
// streams one lane pair per cycle into the multiplier and collects the results.
module fp16_vec_mul_seq
  import fp16_vec_pkg::*;
#(
  parameter int LANES = DEFAULT_LANES,
  parameter int IDXW  = $clog2(LANES)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [FP16_W*LANES-1:0]   vec_a,
  input  logic [FP16_W*LANES-1:0]   vec_b,
  output logic [FP16_W-1:0]         mul_data1,
  output logic [FP16_W-1:0]         mul_data2,
  output logic                      mul_valid,
  input  logic [FP16_W-1:0]         mul_result,
  input  logic                      mul_update,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [FP16_W*LANES-1:0]   vec_out,
  output logic                      seq_err
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid never waits on ready, and the offered data is held until the transfer.

  localparam int              VEC_W    = FP16_W * LANES;
  localparam logic [IDXW:0]   LAST_IDX = (IDXW+1)'(LANES - 1);
  localparam logic [IDXW:0]   IDX_ONE  = (IDXW+1)'(1);

  seq_state_t           state;
  logic [VEC_W-1:0]     a_q;
  logic [VEC_W-1:0]     b_q;
  logic [MAX_VEC_W-1:0] a_ext;
  logic [MAX_VEC_W-1:0] b_ext;
  logic [IDXW:0]        issue_idx;
  logic                 col_start;
  logic                 col_active;
  logic                 col_last;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign col_start  = (state == IDLE) && in_valid;
  assign col_active = (state == ISSUE) || (state == DRAIN);
  assign a_ext      = MAX_VEC_W'(a_q);
  assign b_ext      = MAX_VEC_W'(b_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      issue_idx <= '0;
      mul_data1 <= '0;
      mul_data2 <= '0;
      mul_valid <= 1'b0;
    end else begin
      mul_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q       <= vec_a;
            b_q       <= vec_b;
            // Lane 0 goes out on the acceptance edge so mul_valid covers cycles 1..LANES.
            mul_data1 <= vec_a[FP16_W-1:0];
            mul_data2 <= vec_b[FP16_W-1:0];
            mul_valid <= 1'b1;
            issue_idx <= IDX_ONE;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mul_data1 <= lane_get(a_ext, int'(issue_idx));
          mul_data2 <= lane_get(b_ext, int'(issue_idx));
          mul_valid <= 1'b1;
          issue_idx <= issue_idx + IDX_ONE;
          if (col_last) begin
            state <= DONE;
          end else if (issue_idx == LAST_IDX) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (col_last) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  fp16_vec_collector #(
    .LANES (LANES),
    .IDXW  (IDXW)
  ) u_collector (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (col_start),
    .active     (col_active),
    .mul_update (mul_update),
    .mul_result (mul_result),
    .vec_out    (vec_out),
    .last_wr    (col_last),
    .seq_err    (seq_err)
  );

endmodule
